// File: rtl/bitstream_phase_scheduler_if.sv
// Producer/bit-packer bundle between the header and slice generators,
// the phase scheduler and the downstream bitwriter.
interface bitstream_phase_scheduler_if;
    logic [3:0]   src_start;
    logic [3:0]   src_enable;
    logic [255:0] src_val;
    logic [255:0] src_size;
    logic [3:0]   src_flush;
    logic [3:0]   src_done;
    logic         output_enable;
    logic [63:0]  val;
    logic [63:0]  size_of_bit;
    logic         flush_bit;

    modport master (
        output src_start,
        output output_enable, val, size_of_bit, flush_bit,
        input  src_enable, src_val, src_size, src_flush, src_done
    );

    modport slave (
        input  src_start,
        input  output_enable, val, size_of_bit, flush_bit,
        output src_enable, src_val, src_size, src_flush, src_done
    );
endinterface

// File: rtl/bitstream_phase_scheduler.sv
// Walks one frame through frame/picture/slice header and slice data
// producers, granting the single bit-packer port to one at a time.
module bitstream_phase_scheduler #(
    parameter int NSRC_W  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [15:0]                  num_slices,
    bitstream_phase_scheduler_if.master  bus,
    output logic                         busy,
    output logic                         frame_done,
    output logic [31:0]                  total_bits,
    output logic                         protocol_error
);
    localparam int          NSRC    = 1 << NSRC_W;
    localparam int          BASE_W  = NSRC_W + 6;
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FH, PH, SH, SD, FLUSH, DONE
    } state_t;

    state_t             state;
    logic [15:0]        nslices;
    logic [15:0]        slice_cnt;
    logic [31:0]        wdog;

    logic [NSRC_W-1:0]  act;
    logic               in_phase;
    logic [NSRC-1:0]    act_mask;
    logic [BASE_W-1:0]  base;
    logic               stray;
    logic               en_k;
    logic               done_k;
    logic [63:0]        val_k;
    logic [63:0]        size_k;
    logic               flush_k;

    always_comb begin
        act      = '0;
        in_phase = 1'b0;
        unique case (state)
            FH:      begin act = NSRC_W'(0); in_phase = 1'b1; end
            PH:      begin act = NSRC_W'(1); in_phase = 1'b1; end
            SH:      begin act = NSRC_W'(2); in_phase = 1'b1; end
            SD:      begin act = NSRC_W'(3); in_phase = 1'b1; end
            default: ;
        endcase
        act_mask = '0;
        if (in_phase) act_mask[act] = 1'b1;
        // Anything from a source that does not own the port is a violation
        stray   = |((bus.src_enable | bus.src_done) & ~act_mask);
        en_k    = |(bus.src_enable & act_mask);
        done_k  = |(bus.src_done & act_mask);
        base    = {act, 6'd0};
        val_k   = bus.src_val[base +: 64];
        size_k  = bus.src_size[base +: 64];
        flush_k = bus.src_flush[act];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            nslices           <= '0;
            slice_cnt         <= '0;
            wdog              <= '0;
            bus.src_start     <= '0;
            bus.output_enable <= 1'b0;
            bus.val           <= '0;
            bus.size_of_bit   <= '0;
            bus.flush_bit     <= 1'b0;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
            total_bits        <= '0;
            protocol_error    <= 1'b0;
        end else begin
            bus.src_start     <= '0;
            bus.output_enable <= 1'b0;
            bus.val           <= '0;
            bus.size_of_bit   <= '0;
            bus.flush_bit     <= 1'b0;
            frame_done        <= 1'b0;

            if (in_phase && en_k) begin
                bus.output_enable <= 1'b1;
                bus.val           <= val_k;
                bus.size_of_bit   <= size_k;
                bus.flush_bit     <= flush_k;
                total_bits        <= total_bits + size_k[31:0];
            end

            unique case (state)
                IDLE: if (start) begin
                    nslices        <= num_slices;
                    total_bits     <= '0;
                    protocol_error <= 1'b0;
                    busy           <= 1'b1;
                    wdog           <= '0;
                    state          <= FH;
                    bus.src_start  <= 4'b0001;
                end
                FH, PH, SH, SD: begin
                    if (done_k) begin
                        wdog <= '0;
                        if (state == FH) begin
                            state         <= PH;
                            bus.src_start <= 4'b0010;
                        end else if (state == PH) begin
                            slice_cnt <= '0;
                            if (nslices == 16'd0) begin
                                state <= FLUSH;
                            end else begin
                                state         <= SH;
                                bus.src_start <= 4'b0100;
                            end
                        end else if (state == SH) begin
                            state         <= SD;
                            bus.src_start <= 4'b1000;
                        end else if (slice_cnt + 16'd1 == nslices) begin
                            state <= FLUSH;
                        end else begin
                            slice_cnt     <= slice_cnt + 16'd1;
                            state         <= SH;
                            bus.src_start <= 4'b0100;
                        end
                    end else if (TIMEOUT > 0 && wdog == WD_LAST) begin
                        protocol_error <= 1'b1;
                        state          <= FLUSH;
                    end else begin
                        wdog <= wdog + 32'd1;
                    end
                end
                FLUSH: begin
                    bus.output_enable <= 1'b1;
                    bus.flush_bit     <= 1'b1;
                    state             <= DONE;
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Placed last so a violation in the start cycle is not lost
            if (stray) protocol_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bitstream_phase_scheduler.sv
// Directed scoreboard bench for bitstream_phase_scheduler.
// Words are queued as they are driven and popped when the DUT emits them.
module tb_bitstream_phase_scheduler;
    localparam int TO = 16;

    typedef struct packed {
        logic [63:0] v;
        logic [63:0] s;
        logic        f;
    } word_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_slices = '0;
    logic        busy;
    logic        frame_done;
    logic [31:0] total_bits;
    logic        protocol_error;

    int          checks = 0;
    int          fails = 0;
    int          fd_count = 0;
    int          fd_before;
    logic [31:0] exp_total = '0;
    logic        prev_flush = 1'b0;
    word_t       exp_q[$];
    logic [3:0]  start_log[$];

    bitstream_phase_scheduler_if bus();

    bitstream_phase_scheduler #(
        .NSRC_W (2),
        .TIMEOUT(TO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .num_slices    (num_slices),
        .bus           (bus),
        .busy          (busy),
        .frame_done    (frame_done),
        .total_bits    (total_bits),
        .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_bus();
        bus.src_enable = '0;
        bus.src_done   = '0;
        bus.src_flush  = '0;
        bus.src_val    = '0;
        bus.src_size   = '0;
    endtask

    task automatic do_start(input logic [15:0] n);
        start_log.delete();
        exp_total  = '0;
        start      = 1'b1;
        num_slices = n;
        tick();
        start = 1'b0;
    endtask

    task automatic emit(input int k, input logic [63:0] v,
                        input logic [63:0] s, input logic done);
        bus.src_enable[k]        = 1'b1;
        bus.src_val[64*k +: 64]  = v;
        bus.src_size[64*k +: 64] = s;
        bus.src_done[k]          = done;
        exp_q.push_back('{v: v, s: s, f: 1'b0});
        exp_total = exp_total + s[31:0];
        tick();
        clear_bus();
    endtask

    task automatic expect_flush();
        exp_q.push_back('{v: 64'd0, s: 64'd0, f: 1'b1});
    endtask

    function automatic logic [31:0] pack_log();
        logic [31:0] p = '0;
        foreach (start_log[i]) p = {p[27:0], start_log[i]};
        return p;
    endfunction

    always @(negedge clock) begin
        word_t w;
        if (bus.output_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {63'd0, bus.output_enable}, 64'd0);
            end else begin
                w = exp_q.pop_front();
                chk("word_val", bus.val, w.v);
                chk("word_size", bus.size_of_bit, w.s);
                chk("word_flush", {63'd0, bus.flush_bit}, {63'd0, w.f});
            end
        end
        if (frame_done === 1'b1) begin
            fd_count++;
            chk("fd_after_flush", {63'd0, prev_flush}, 64'd1);
        end
        prev_flush = bus.output_enable & bus.flush_bit;
        if (bus.src_start != 4'd0) start_log.push_back(bus.src_start);
    end

    initial begin
        clear_bus();
        tick();
        tick();
        chk("rst_oe", {63'd0, bus.output_enable}, 64'd0);
        chk("rst_start", {60'd0, bus.src_start}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_total", {32'd0, total_bits}, 64'd0);
        chk("rst_err", {63'd0, protocol_error}, 64'd0);
        reset_n = 1'b1;
        tick();

        // Two-slice frame, with a start pulse during PH that must be ignored
        fd_before = fd_count;
        do_start(16'd2);
        chk("busy_fh", {63'd0, busy}, 64'd1);
        emit(0, 64'h11, 64'd32, 1'b0);
        emit(0, 64'h12, 64'd32, 1'b0);
        emit(0, 64'h13, 64'd16, 1'b1);
        start = 1'b1;
        emit(1, 64'h21, 64'd8, 1'b0);
        start = 1'b0;
        emit(1, 64'h22, 64'd8, 1'b1);
        for (int s = 0; s < 2; s++) begin
            emit(2, 64'h30 + 64'(s), 64'd16, 1'b1);
            for (int w = 0; w < 4; w++)
                emit(3, 64'h400 + 64'(s * 4 + w), 64'd20, w == 3);
        end
        expect_flush();
        repeat (4) tick();
        chk("a_seq", {32'd0, pack_log()}, 64'h0012_4848);
        chk("a_total", {32'd0, total_bits}, {32'd0, exp_total});
        chk("a_fd", 64'(fd_count), 64'(fd_before + 1));
        chk("a_busy", {63'd0, busy}, 64'd0);
        chk("a_err", {63'd0, protocol_error}, 64'd0);
        chk("a_q", 64'(exp_q.size()), 64'd0);

        // Zero slices: PH goes straight to FLUSH
        fd_before = fd_count;
        do_start(16'd0);
        emit(0, 64'hF0, 64'd40, 1'b1);
        emit(1, 64'hF1, 64'd24, 1'b1);
        expect_flush();
        repeat (4) tick();
        chk("b_seq", {32'd0, pack_log()}, 64'h12);
        chk("b_total", {32'd0, total_bits}, {32'd0, exp_total});
        chk("b_fd", 64'(fd_count), 64'(fd_before + 1));
        chk("b_q", 64'(exp_q.size()), 64'd0);

        // Slice-data source talks during SH
        do_start(16'd1);
        emit(0, 64'h1, 64'd8, 1'b1);
        emit(1, 64'h2, 64'd8, 1'b1);
        bus.src_enable[3]      = 1'b1;
        bus.src_val[255:192]   = 64'hABCD;
        bus.src_size[255:192]  = 64'd16;
        tick();
        clear_bus();
        chk("c_oe_blocked", {63'd0, bus.output_enable}, 64'd0);
        chk("c_err_set", {63'd0, protocol_error}, 64'd1);
        emit(2, 64'h3, 64'd16, 1'b1);
        emit(3, 64'h4, 64'd20, 1'b1);
        expect_flush();
        repeat (4) tick();
        chk("c_err_sticky", {63'd0, protocol_error}, 64'd1);
        chk("c_total", {32'd0, total_bits}, {32'd0, exp_total});
        do_start(16'd0);
        chk("c_err_clr", {63'd0, protocol_error}, 64'd0);
        emit(0, 64'h5, 64'd8, 1'b1);
        emit(1, 64'h6, 64'd8, 1'b1);
        expect_flush();
        repeat (4) tick();
        chk("c_q", 64'(exp_q.size()), 64'd0);

        // SD never signals done: watchdog forces the flush
        fd_before = fd_count;
        do_start(16'd1);
        emit(0, 64'h7, 64'd8, 1'b1);
        emit(1, 64'h8, 64'd8, 1'b1);
        emit(2, 64'h9, 64'd16, 1'b1);
        expect_flush();
        repeat (TO - 1) tick();
        chk("d_err_early", {63'd0, protocol_error}, 64'd0);
        tick();
        chk("d_err_timeout", {63'd0, protocol_error}, 64'd1);
        repeat (3) tick();
        chk("d_fd", 64'(fd_count), 64'(fd_before + 1));
        chk("d_busy", {63'd0, busy}, 64'd0);
        chk("d_q", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of slice data
        do_start(16'd1);
        emit(0, 64'hA, 64'd8, 1'b1);
        emit(1, 64'hB, 64'd8, 1'b1);
        emit(2, 64'hC, 64'd16, 1'b1);
        bus.src_enable[3]     = 1'b1;
        bus.src_val[255:192]  = 64'h5A5A;
        bus.src_size[255:192] = 64'd20;
        tick();
        chk("e_oe_pre", {63'd0, bus.output_enable}, 64'd1);
        chk("e_val_pre", bus.val, 64'h5A5A);
        fd_before = fd_count;
        #1 reset_n = 1'b0;
        #1;
        chk("e_oe_rst", {63'd0, bus.output_enable}, 64'd0);
        chk("e_val_rst", bus.val, 64'd0);
        chk("e_size_rst", bus.size_of_bit, 64'd0);
        chk("e_busy_rst", {63'd0, busy}, 64'd0);
        chk("e_total_rst", {32'd0, total_bits}, 64'd0);
        clear_bus();
        tick();
        reset_n = 1'b1;
        tick();
        chk("e_no_fd", 64'(fd_count), 64'(fd_before));
        do_start(16'd0);
        emit(0, 64'hD, 64'd8, 1'b1);
        emit(1, 64'hE, 64'd8, 1'b1);
        expect_flush();
        repeat (4) tick();
        chk("e_total", {32'd0, total_bits}, {32'd0, exp_total});
        chk("e_fd", 64'(fd_count), 64'(fd_before + 1));
        chk("e_err", {63'd0, protocol_error}, 64'd0);
        chk("e_q", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
